// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: writeback, read ports, issue reservation and HI/LO.
// The master drives requests; the register file (slave) returns data and status.
interface regfile_sb_if #(
    parameter int DW  = 32,
    parameter int AW  = 5,
    parameter int NRD = 2
);
    logic              we;
    logic [AW-1:0]     waddr;
    logic [DW-1:0]     wdata;
    logic [NRD-1:0]    re;
    logic [NRD*AW-1:0] raddr;
    logic [NRD*DW-1:0] rdata;
    logic [NRD-1:0]    rbusy;
    logic              iss_valid;
    logic [AW-1:0]     iss_addr;
    logic              iss_ready;
    logic              we_hi;
    logic              we_lo;
    logic [DW-1:0]     wdata_hi;
    logic [DW-1:0]     wdata_lo;
    logic              re_hilo;
    logic [DW-1:0]     rdata_hi;
    logic [DW-1:0]     rdata_lo;
    logic              sb_err;

    modport master (
        output we, waddr, wdata, re, raddr, iss_valid, iss_addr,
               we_hi, we_lo, wdata_hi, wdata_lo, re_hilo,
        input  rdata, rbusy, iss_ready, rdata_hi, rdata_lo, sb_err
    );

    modport slave (
        input  we, waddr, wdata, re, raddr, iss_valid, iss_addr,
               we_hi, we_lo, wdata_hi, wdata_lo, re_hilo,
        output rdata, rbusy, iss_ready, rdata_hi, rdata_lo, sb_err
    );
endinterface

// File: rtl/regfile_sb.sv
// Parametrised register file with HI/LO, write-to-read bypass and a per-register
// saturating pending-write scoreboard for RAW hazard detection at issue.
module regfile_sb #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int NRD      = 2,
    parameter int PW       = 2,
    parameter int ZERO_REG = 1
) (
    input logic         clk,
    input logic         rst,
    regfile_sb_if.slave bus
);
    localparam int unsigned  DEPTH = 1 << AW;
    localparam bit           ZR    = (ZERO_REG != 0);
    localparam logic [PW-1:0] PMAX = '1;

    logic [DW-1:0] regs [DEPTH];
    logic [PW-1:0] pend [DEPTH];
    logic [DW-1:0] hi_q;
    logic [DW-1:0] lo_q;
    logic          err_q;

    logic w_zero;
    logic i_zero;
    logic dec;
    logic inc;
    logic ready_c;

    assign w_zero = ZR && (bus.waddr == '0);
    assign i_zero = ZR && (bus.iss_addr == '0);
    assign dec    = bus.we && !w_zero;

    // A retire to the same register this cycle frees a slot for the new reservation.
    assign ready_c = i_zero || (pend[bus.iss_addr] != PMAX) ||
                     (dec && (bus.waddr == bus.iss_addr));
    assign inc     = bus.iss_valid && ready_c && !i_zero;

    assign bus.iss_ready = rst || ready_c;
    assign bus.sb_err    = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned a = 0; a < DEPTH; a++) begin
                regs[a] <= '0;
                pend[a] <= '0;
            end
            hi_q  <= '0;
            lo_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (dec) regs[bus.waddr] <= bus.wdata;
            if (bus.we_hi) hi_q <= bus.wdata_hi;
            if (bus.we_lo) lo_q <= bus.wdata_lo;
            if (dec && (pend[bus.waddr] == '0)) err_q <= 1'b1;
            if (inc && !(dec && (bus.iss_addr == bus.waddr)))
                pend[bus.iss_addr] <= pend[bus.iss_addr] + 1'b1;
            if (dec && !(inc && (bus.iss_addr == bus.waddr)) && (pend[bus.waddr] != '0))
                pend[bus.waddr] <= pend[bus.waddr] - 1'b1;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] ra;
        logic          rz;
        logic          hit;
        logic [DW-1:0] rd;
        logic          busy;

        assign ra  = bus.raddr[i*AW +: AW];
        assign rz  = ZR && (ra == '0);
        assign hit = dec && (bus.waddr == ra);

        always_comb begin
            rd   = '0;
            busy = 1'b0;
            if (!rst && bus.re[i] && !rz) begin
                rd   = hit ? bus.wdata : regs[ra];
                // The final outstanding write is satisfied by the bypass path.
                busy = (pend[ra] != '0) && !((pend[ra] == PW'(1)) && hit);
            end
        end

        assign bus.rdata[i*DW +: DW] = rd;
        assign bus.rbusy[i]          = busy;
    end

    always_comb begin
        bus.rdata_hi = '0;
        bus.rdata_lo = '0;
        if (!rst && bus.re_hilo) begin
            bus.rdata_hi = bus.we_hi ? bus.wdata_hi : hi_q;
            bus.rdata_lo = bus.we_lo ? bus.wdata_lo : lo_q;
        end
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a spec-level model checked every cycle plus
// hand-computed expectations at key points of the sequence.
module tb_regfile_sb;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NRD = 2;
    localparam int PW = 2;
    localparam int MAXP = (1 << PW) - 1;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    regfile_sb_if #(.DW(DW), .AW(AW), .NRD(NRD)) bus ();

    regfile_sb #(.DW(DW), .AW(AW), .NRD(NRD), .PW(PW), .ZERO_REG(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] m_regs [32];
    int            m_pend [32];
    logic [DW-1:0] m_hi;
    logic [DW-1:0] m_lo;
    bit            m_err;
    bit            m_inc;
    bit            m_dec;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_rd(input int p);
        logic [AW-1:0] ra;
        ra = bus.raddr[p*AW +: AW];
        if (rst || !bus.re[p] || ra == 0) return '0;
        if (bus.we && bus.waddr == ra) return bus.wdata;
        return m_regs[ra];
    endfunction

    function automatic bit exp_busy(input int p);
        logic [AW-1:0] ra;
        int outstanding;
        ra = bus.raddr[p*AW +: AW];
        if (rst || !bus.re[p] || ra == 0) return 1'b0;
        outstanding = m_pend[ra] - ((bus.we && bus.waddr == ra) ? 1 : 0);
        return outstanding > 0;
    endfunction

    function automatic bit exp_ready();
        int free_slots;
        if (rst || bus.iss_addr == 0) return 1'b1;
        free_slots = MAXP - m_pend[bus.iss_addr] +
                     ((bus.we && bus.waddr == bus.iss_addr) ? 1 : 0);
        return free_slots > 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int a = 0; a < 32; a++) begin
                m_regs[a] = '0;
                m_pend[a] = 0;
            end
            m_hi  = '0;
            m_lo  = '0;
            m_err = 1'b0;
        end else begin
            m_inc = bus.iss_valid && exp_ready() && bus.iss_addr != 0;
            m_dec = bus.we && bus.waddr != 0;
            if (m_dec && m_pend[bus.waddr] == 0) m_err = 1'b1;
            if (m_inc) m_pend[bus.iss_addr] = m_pend[bus.iss_addr] + 1;
            if (m_dec && m_pend[bus.waddr] > 0) m_pend[bus.waddr] = m_pend[bus.waddr] - 1;
            if (m_dec) m_regs[bus.waddr] = bus.wdata;
            if (bus.we_hi) m_hi = bus.wdata_hi;
            if (bus.we_lo) m_lo = bus.wdata_lo;
        end
    end

    always @(negedge clk) begin
        for (int p = 0; p < NRD; p++) begin
            chk($sformatf("rdata%0d", p), 64'(bus.rdata[p*DW +: DW]), 64'(exp_rd(p)));
            chk($sformatf("rbusy%0d", p), 64'(bus.rbusy[p]), 64'(exp_busy(p)));
        end
        chk("iss_ready", 64'(bus.iss_ready), 64'(exp_ready()));
        chk("sb_err", 64'(bus.sb_err), 64'(m_err));
        chk("rdata_hi", 64'(bus.rdata_hi),
            64'((rst || !bus.re_hilo) ? '0 : (bus.we_hi ? bus.wdata_hi : m_hi)));
        chk("rdata_lo", 64'(bus.rdata_lo),
            64'((rst || !bus.re_hilo) ? '0 : (bus.we_lo ? bus.wdata_lo : m_lo)));
    end

    task automatic idle();
        bus.we = 1'b0;        bus.waddr = '0;      bus.wdata = '0;
        bus.re = '0;          bus.raddr = '0;
        bus.iss_valid = 1'b0; bus.iss_addr = '0;
        bus.we_hi = 1'b0;     bus.we_lo = 1'b0;
        bus.wdata_hi = '0;    bus.wdata_lo = '0;   bus.re_hilo = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        idle();
        rst = 1'b1;
        bus.re = 2'b11;
        bus.raddr = {5'd3, 5'd3};
        bus.iss_valid = 1'b1;
        bus.iss_addr = 5'd4;
        tick(); #1;
        chk("rst_rdata", 64'(bus.rdata), 64'h0);
        chk("rst_rbusy", 64'(bus.rbusy), 64'h0);
        chk("rst_ready", 64'(bus.iss_ready), 64'h1);
        chk("rst_err", 64'(bus.sb_err), 64'h0);
        tick();
        rst = 1'b0;
        bus.iss_valid = 1'b0;
        bus.raddr = {5'd3, 5'd4};
        #1 chk("r4_not_reserved", 64'(bus.rbusy[0]), 64'h0);

        tick();
        bus.we = 1'b1; bus.waddr = 5'd5; bus.wdata = 32'hDEADBEEF;
        bus.raddr = {5'd3, 5'd5};
        #1 chk("bypass_r5", 64'(bus.rdata[31:0]), 64'hDEADBEEF);
        tick();
        bus.we = 1'b0;
        #1 chk("stored_r5", 64'(bus.rdata[31:0]), 64'hDEADBEEF);
        chk("err_after_r5", 64'(bus.sb_err), 64'h1);
        tick();
        bus.we = 1'b1; bus.waddr = 5'd0; bus.wdata = 32'h1234;
        bus.raddr = {5'd3, 5'd0};
        #1 chk("r0_bypass_zero", 64'(bus.rdata[31:0]), 64'h0);
        tick();
        bus.we = 1'b0;
        #1 chk("r0_stored_zero", 64'(bus.rdata[31:0]), 64'h0);

        tick();
        bus.iss_valid = 1'b1; bus.iss_addr = 5'd7;
        bus.raddr = {5'd7, 5'd7};
        #1 chk("iss1_ready", 64'(bus.iss_ready), 64'h1);
        chk("iss1_rbusy", 64'(bus.rbusy), 64'h0);
        tick(); #1 chk("iss2_ready", 64'(bus.iss_ready), 64'h1);
        tick(); #1 chk("iss3_ready", 64'(bus.iss_ready), 64'h1);
        chk("iss3_rbusy", 64'(bus.rbusy), 64'h3);
        tick(); #1 chk("full_ready", 64'(bus.iss_ready), 64'h0);
        chk("full_rbusy", 64'(bus.rbusy), 64'h3);
        tick();
        bus.we = 1'b1; bus.waddr = 5'd7; bus.wdata = 32'h70;
        #1 chk("retire_frees", 64'(bus.iss_ready), 64'h1);
        tick();
        bus.we = 1'b0;
        #1 chk("still_full", 64'(bus.iss_ready), 64'h0);
        tick();
        bus.iss_valid = 1'b0;
        bus.we = 1'b1; bus.wdata = 32'h71;
        tick();
        bus.wdata = 32'h72;
        tick();
        bus.we = 1'b0;
        #1 chk("pend1_rbusy", 64'(bus.rbusy), 64'h3);
        tick();
        bus.we = 1'b1; bus.wdata = 32'h73;
        #1 chk("last_rbusy", 64'(bus.rbusy), 64'h0);
        chk("last_bypass", 64'(bus.rdata[63:32]), 64'h73);
        tick();
        bus.we = 1'b0;
        #1 chk("pend0_rbusy", 64'(bus.rbusy), 64'h0);
        chk("r7_stored", 64'(bus.rdata[63:32]), 64'h73);

        tick();
        bus.we = 1'b1; bus.waddr = 5'd9; bus.wdata = 32'h99;
        bus.raddr = {5'd9, 5'd9};
        tick();
        bus.we = 1'b0;
        #1 chk("r9_stored", 64'(bus.rdata[63:32]), 64'h99);
        chk("err_sticky", 64'(bus.sb_err), 64'h1);

        tick();
        bus.re_hilo = 1'b1; bus.we_lo = 1'b1; bus.wdata_lo = 32'h5A5A0001;
        #1 chk("lo_bypass", 64'(bus.rdata_lo), 64'h5A5A0001);
        tick();
        bus.we_lo = 1'b0; bus.we_hi = 1'b1; bus.wdata_hi = 32'hA5A5A5A5;
        #1 chk("hi_bypass", 64'(bus.rdata_hi), 64'hA5A5A5A5);
        chk("lo_kept", 64'(bus.rdata_lo), 64'h5A5A0001);
        tick();
        bus.we_hi = 1'b0; bus.re_hilo = 1'b0;
        #1 chk("hilo_off", 64'({bus.rdata_hi, bus.rdata_lo}), 64'h0);
        tick();
        bus.re_hilo = 1'b1;
        #1 chk("hi_stored", 64'(bus.rdata_hi), 64'hA5A5A5A5);

        tick();
        bus.we = 1'b1; bus.waddr = 5'd5; bus.wdata = 32'h55;
        bus.raddr = {5'd5, 5'd5};
        bus.iss_valid = 1'b1; bus.iss_addr = 5'd7;
        bus.we_hi = 1'b1; bus.wdata_hi = 32'h1111;
        #2 rst = 1'b1;
        #1 chk("arst_rdata", 64'(bus.rdata), 64'h0);
        chk("arst_rbusy", 64'(bus.rbusy), 64'h0);
        chk("arst_hilo", 64'({bus.rdata_hi, bus.rdata_lo}), 64'h0);
        chk("arst_err", 64'(bus.sb_err), 64'h0);
        chk("arst_ready", 64'(bus.iss_ready), 64'h1);
        tick();
        rst = 1'b0;
        bus.we = 1'b0; bus.iss_valid = 1'b0; bus.we_hi = 1'b0;
        #1 chk("r5_cleared", 64'(bus.rdata[31:0]), 64'h0);
        chk("hi_cleared", 64'(bus.rdata_hi), 64'h0);
        chk("r7_not_pending", 64'(bus.rbusy), 64'h0);
        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised general-purpose register file for the openMIPS core. It replaces the fixed 32x32 file with configurable width, depth and read-port count. It adds a per-register pending-write scoreboard built from saturating counters, so the issue stage can stall on RAW hazards. It also provides HI/LO registers with independent write enables and same-cycle write-to-read bypass on every read path.

Parameters:
DW, 32, data width of every register, HI and LO
AW, 5, register address width; depth = 2**AW
NRD, 2, number of read ports (>=1)
PW, 2, scoreboard counter width; max outstanding writes per register = 2**PW-1
ZERO_REG, 1, 1 = register 0 reads as zero, ignores writes, never pending

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
we  in  1  writeback enable; also retires one pending write of waddr
waddr  in  AW  writeback address
wdata  in  DW  writeback data
re  in  NRD  per-port read enable
raddr  in  NRD*AW  packed read addresses, port i at [i*AW +: AW]
rdata  out  NRD*DW  packed read data, port i at [i*DW +: DW]
rbusy  out  NRD  port i operand still pending (RAW hazard)
iss_valid  in  1  issue stage reserves destination iss_addr
iss_addr  in  AW  destination being reserved
iss_ready  out  1  reservation can be accepted this cycle
we_hi  in  1  HI write enable
we_lo  in  1  LO write enable
wdata_hi  in  DW  HI write data
wdata_lo  in  DW  LO write data
re_hilo  in  1  HI/LO read enable
rdata_hi  out  DW  HI read data
rdata_lo  out  DW  LO read data
sb_err  out  1  sticky: a retire hit a zero counter

Behaviour:
- Reset (async, rst=1):
  - all registers, HI, LO and all pend counters cleared to 0; sb_err=0.
  - While rst=1, rdata/rdata_hi/rdata_lo=0 and rbusy=0.
  - iss_ready=1 during reset; issues presented during reset are not recorded.
- Register write:
  - On clk rising edge, if we and not (ZERO_REG and waddr==0), regs[waddr]<=wdata.
  - New value visible in storage the next cycle.
- Read port i (combinational, zero latency), priority order:
  - re[i]=0 -> 0
  - ZERO_REG and raddr_i==0 -> 0
  - we and waddr==raddr_i -> wdata (bypass)
  - else regs[raddr_i]
- HI/LO:
  - HI and LO update independently on the edge with we_hi and we_lo.
  - rdata_hi = re_hilo ? (we_hi ? wdata_hi : HI) : 0; rdata_lo likewise with we_lo.
- Scoreboard, one counter pend[a] per register:
  - inc = iss_valid and iss_ready and not (ZERO_REG and iss_addr==0).
  - dec = we and not (ZERO_REG and waddr==0).
  - Same address, inc and dec together -> counter unchanged. Different addresses -> each updated independently.
  - dec when pend[waddr]==0 -> counter stays 0, sb_err<=1 (sticky until rst); the data write still occurs.
  - iss_ready = 0 only when pend[iss_addr]==2**PW-1 and not (dec and waddr==iss_addr). A same-cycle retire frees the slot.
  - iss_ready is always 1 for r0 when ZERO_REG.
  - iss_ready must not depend combinationally on iss_valid.
- rbusy[i] = re[i] and not r0 and pend[raddr_i]!=0 and not (pend[raddr_i]==1 and dec and waddr==raddr_i).
  - The last outstanding write is covered by the bypass, so the operand is not busy.
- No other latency: a reservation raises rbusy for that address starting the cycle after acceptance.
- Reset asserted mid-operation discards all pending state; no write completes in the reset cycle.

Test Plan:
- Reset then read all ports, re=all 1, raddr=3 -> rdata=0, rbusy=0, iss_ready=1, sb_err=0.
- Write r5=0xDEADBEEF with port0 raddr=5 in the same cycle -> port0 rdata=0xDEADBEEF (bypass); next cycle from storage, still 0xDEADBEEF. Write r0=0x1234 -> r0 reads 0.
- Issue r7 three times (PW=2) -> pend=3, iss_ready=0 for iss_addr=7 and rbusy=1 on port reading r7.
  - Same cycle, we waddr=7 and iss_valid iss_addr=7 -> iss_ready=1, pend stays 3.
- Retire r7 down to pend=1, then retire with port1 raddr=7 -> rbusy[1]=0 and rdata=wdata that cycle; afterwards pend=0.
- we waddr=9 with pend[9]=0 -> sb_err=1 and r9 written; sb_err stays 1 until rst.
- we_hi=1 wdata_hi=0xA5A5A5A5, we_lo=0 -> rdata_hi bypasses 0xA5A5A5A5 and LO keeps its prior value; re_hilo=0 -> both 0. Assert rst asynchronously between edges -> all outputs 0 immediately.
